// File: rtl/spi_slave_gen_if.sv
// rtl/spi_slave_gen_if.sv - SPI pins plus RAM-side handshake bundle for spi_slave_gen
interface spi_slave_gen_if #(
  parameter int DATA_W = 8
);
  logic              ss_n;
  logic              mosi;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              miso;
  logic              rx_valid;
  logic [DATA_W+1:0] rx_data;
  logic              busy;
  logic              frame_err;
  logic              rd_pending;

  modport slave (
    input  ss_n, mosi, tx_valid, tx_data,
    output miso, rx_valid, rx_data, busy, frame_err, rd_pending
  );

  modport master (
    output ss_n, mosi, tx_valid, tx_data,
    input  miso, rx_valid, rx_data, busy, frame_err, rd_pending
  );
endinterface

// File: rtl/spi_slave_gen.sv
// rtl/spi_slave_gen.sv - parametrised SPI slave front-end for the single-port RAM
// Frames are {cmd[1:0], payload}; mosi is sampled once per clk while ss_n is low.
module spi_slave_gen #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 1,
  parameter int TX_TIMEOUT = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  spi_slave_gen_if.slave bus_io
);
  localparam int F  = DATA_W + 2;
  localparam int CW = $clog2(F);
  localparam int TW = $clog2(TX_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_RX   = CW'(F - 1);
  localparam logic [CW-1:0] CNT_TX   = CW'(DATA_W - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, RX, WAIT_TX, TX, DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [TW-1:0]     tmo_q;
  logic [1:0]        cmd_q;
  logic [DATA_W-1:0] pay_q, pay_d;
  logic [DATA_W-1:0] txsh_q, txsh_d;
  logic              tx_bit;
  logic              miso_q, rx_valid_q, frame_err_q, rd_pending_q;
  logic [F-1:0]      rx_data_q;

  always_comb begin
    pay_d  = pay_q;
    txsh_d = txsh_q;
    tx_bit = 1'b0;
    if (MSB_FIRST != 0) begin
      pay_d  = (pay_q << 1) | DATA_W'(bus_io.mosi);
      txsh_d = txsh_q << 1;
      tx_bit = txsh_q[DATA_W-1];
    end else begin
      pay_d  = (pay_q >> 1) | (DATA_W'(bus_io.mosi) << (DATA_W - 1));
      txsh_d = txsh_q >> 1;
      tx_bit = txsh_q[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      cmd_q        <= '0;
      pay_q        <= '0;
      txsh_q       <= '0;
      miso_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      frame_err_q  <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          cnt_q  <= '0;
          tmo_q  <= '0;
          if (!bus_io.ss_n) state_q <= CHK_CMD;
        end
        CHK_CMD: begin
          if (bus_io.ss_n) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
          end else begin
            cmd_q[1] <= bus_io.mosi;
            cnt_q    <= CNT_RX;
            state_q  <= RX;
          end
        end
        RX: begin
          // The load cycle completes the frame, so a release seen here is not an abort.
          if (cnt_q == '0) begin
            rx_data_q  <= {cmd_q, pay_q};
            rx_valid_q <= 1'b1;
            if (cmd_q == 2'b11) begin
              tmo_q   <= '0;
              state_q <= WAIT_TX;
            end else begin
              if (cmd_q == 2'b10) rd_pending_q <= 1'b1;
              state_q <= DONE;
            end
          end else if (bus_io.ss_n) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            if (cnt_q == CNT_RX) cmd_q[0] <= bus_io.mosi;
            else                 pay_q    <= pay_d;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WAIT_TX: begin
          if (bus_io.ss_n) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
            tmo_q       <= '0;
          end else if (bus_io.tx_valid) begin
            txsh_q  <= bus_io.tx_data;
            cnt_q   <= CNT_TX;
            tmo_q   <= '0;
            state_q <= TX;
          end else if (tmo_q == TMO_LAST) begin
            frame_err_q  <= 1'b1;
            rd_pending_q <= 1'b0;
            tmo_q        <= '0;
            state_q      <= DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        TX: begin
          if (bus_io.ss_n) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
            miso_q      <= 1'b0;
            cnt_q       <= '0;
          end else begin
            miso_q <= tx_bit;
            txsh_q <= txsh_d;
            if (cnt_q == '0) begin
              rd_pending_q <= 1'b0;
              state_q      <= DONE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        DONE: begin
          miso_q <= 1'b0;
          if (bus_io.ss_n) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.miso       = miso_q;
  assign bus_io.rx_valid   = rx_valid_q;
  assign bus_io.rx_data    = rx_data_q;
  assign bus_io.busy       = (state_q != IDLE);
  assign bus_io.frame_err  = frame_err_q;
  assign bus_io.rd_pending = rd_pending_q;
endmodule

// File: tb/tb_spi_slave_gen.sv
// tb/tb_spi_slave_gen.sv - randomized self-checking bench for spi_slave_gen
// Instance a is MSB-first, instance b LSB-first; both DATA_W=8, TX_TIMEOUT=16.
module tb_spi_slave_gen;
  localparam int F_W     = 10;
  localparam int RV_LAT  = F_W + 1;
  localparam int TMO_LAT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   cur = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [9:0] last_rx_a = '0;
  logic       pend_a = 1'b0;

  spi_slave_gen_if #(.DATA_W(8)) a_if ();
  spi_slave_gen_if #(.DATA_W(8)) b_if ();

  spi_slave_gen #(.DATA_W(8), .MSB_FIRST(1), .TX_TIMEOUT(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus_io(a_if.slave));
  spi_slave_gen #(.DATA_W(8), .MSB_FIRST(0), .TX_TIMEOUT(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus_io(b_if.slave));

  logic       o_miso, o_rx_valid, o_busy, o_frame_err, o_rd_pending;
  logic [9:0] o_rx_data;
  assign o_miso       = cur ? b_if.miso       : a_if.miso;
  assign o_rx_valid   = cur ? b_if.rx_valid   : a_if.rx_valid;
  assign o_rx_data    = cur ? b_if.rx_data    : a_if.rx_data;
  assign o_busy       = cur ? b_if.busy       : a_if.busy;
  assign o_frame_err  = cur ? b_if.frame_err  : a_if.frame_err;
  assign o_rd_pending = cur ? b_if.rd_pending : a_if.rd_pending;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit sel, input logic ss, input logic mo);
    if (sel) begin b_if.ss_n = ss; b_if.mosi = mo; end
    else     begin a_if.ss_n = ss; a_if.mosi = mo; end
  endtask

  task automatic release_ss(input bit sel);
    set_in(sel, 1'b1, 1'b0);
    tick();
  endtask

  // Serial order of a frame: index 0 goes on the wire first.
  function automatic logic [9:0] frame_seq(input logic [1:0] cmd, input logic [7:0] pay, input bit msb_first);
    logic [9:0] s;
    s[0] = cmd[1];
    s[1] = cmd[0];
    for (int k = 0; k < 8; k++) s[2+k] = msb_first ? pay[7-k] : pay[k];
    return s;
  endfunction

  task automatic send_frame(input bit sel, input logic [1:0] cmd, input logic [7:0] pay,
                            input bit msb_first, input bit rel_early,
                            output int rv_cyc, output logic [9:0] rv_data,
                            output int n_rv, output int n_ferr);
    logic [9:0] seq;
    seq = frame_seq(cmd, pay, msb_first);
    cur = sel; rv_cyc = -1; rv_data = '0; n_rv = 0; n_ferr = 0;
    set_in(sel, 1'b0, 1'b0);
    tick();
    for (int e = 1; e <= F_W + 1; e++) begin
      if (e <= F_W) set_in(sel, 1'b0, seq[e-1]);
      else          set_in(sel, rel_early, 1'b0);
      tick();
      if (o_rx_valid === 1'b1) begin
        n_rv++;
        if (rv_cyc < 0) begin rv_cyc = e; rv_data = o_rx_data; end
      end
      if (o_frame_err === 1'b1) n_ferr++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      cur = s[0];
      #1;
      total_cnt++; if (o_miso !== 1'b0) $display("FAIL reset_miso dut%0d got=%b exp=0", s, o_miso); else pass_cnt++;
      total_cnt++; if (o_rx_valid !== 1'b0) $display("FAIL reset_rx_valid dut%0d got=%b exp=0", s, o_rx_valid); else pass_cnt++;
      total_cnt++; if (o_rx_data !== 10'h0) $display("FAIL reset_rx_data dut%0d got=%h exp=000", s, o_rx_data); else pass_cnt++;
      total_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy dut%0d got=%b exp=0", s, o_busy); else pass_cnt++;
      total_cnt++; if (o_frame_err !== 1'b0) $display("FAIL reset_frame_err dut%0d got=%b exp=0", s, o_frame_err); else pass_cnt++;
      total_cnt++; if (o_rd_pending !== 1'b0) $display("FAIL reset_rd_pending dut%0d got=%b exp=0", s, o_rd_pending); else pass_cnt++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rx_frames(input bit sel);
    int rv_cyc, n_rv, n_ferr, bad;
    logic [9:0] rv_data, exp;
    logic [1:0] cmd;
    logic [7:0] pay;
    bit rel;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        cmd = sel ? 2'b01 : 2'b00;
        pay = sel ? 8'h01 : 8'hA5;
        rel = 1'b0;
      end else begin
        cmd = 2'($urandom_range(0, 1));
        pay = 8'($urandom);
        rel = 1'($urandom_range(0, 1));
      end
      exp = {cmd, pay};
      send_frame(sel, cmd, pay, !sel, rel, rv_cyc, rv_data, n_rv, n_ferr);
      total_cnt++; if (rv_cyc !== RV_LAT) $display("FAIL rx_latency dut%0d frame%0d got=%0d exp=%0d", sel, i, rv_cyc, RV_LAT); else pass_cnt++;
      total_cnt++; if (rv_data !== exp) $display("FAIL rx_data dut%0d frame%0d got=%h exp=%h", sel, i, rv_data, exp); else pass_cnt++;
      total_cnt++; if (n_rv !== 1 || n_ferr !== 0) $display("FAIL rx_pulses dut%0d frame%0d rv=%0d ferr=%0d exp=1,0", sel, i, n_rv, n_ferr); else pass_cnt++;
      if (!sel) last_rx_a = exp;
      bad = 0;
      if (!rel) begin
        for (int t = 0; t < 3; t++) begin
          set_in(sel, 1'b0, 1'($urandom));
          tick();
          if (o_busy !== 1'b1 || o_rx_valid !== 1'b0) bad++;
        end
        total_cnt++; if (bad != 0) $display("FAIL done_hold dut%0d frame%0d bad_cycles=%0d exp=0", sel, i, bad); else pass_cnt++;
        set_in(sel, 1'b1, 1'b0);
      end
      tick();
      total_cnt++; if (o_busy !== 1'b0 || o_rd_pending !== 1'b0) $display("FAIL released dut%0d frame%0d busy=%b pend=%b exp=0,0", sel, i, o_busy, o_rd_pending); else pass_cnt++;
    end
    cur = 1'b0;
  endtask

  task automatic test_read();
    int rv_cyc, n_rv, n_ferr, d, bad;
    logic [9:0] rv_data;
    logic [7:0] addr, data, pay;
    bit level;
    for (int it = 0; it < 4; it++) begin
      addr  = 8'($urandom);
      data  = (it == 0) ? 8'h5A : 8'($urandom);
      pay   = (it == 0) ? 8'h00 : 8'($urandom);
      d     = (it == 0) ? 2 : $urandom_range(0, 8);
      level = it[0];
      send_frame(1'b0, 2'b10, addr, 1'b1, 1'b0, rv_cyc, rv_data, n_rv, n_ferr);
      total_cnt++; if (rv_data !== {2'b10, addr}) $display("FAIL rd_addr_data it%0d got=%h exp=%h", it, rv_data, {2'b10, addr}); else pass_cnt++;
      total_cnt++; if (o_rd_pending !== 1'b1) $display("FAIL rd_pending_set it%0d got=%b exp=1", it, o_rd_pending); else pass_cnt++;
      release_ss(1'b0);
      tick();
      send_frame(1'b0, 2'b11, pay, 1'b1, 1'b0, rv_cyc, rv_data, n_rv, n_ferr);
      last_rx_a = {2'b11, pay};
      total_cnt++; if (rv_cyc !== RV_LAT || rv_data !== {2'b11, pay}) $display("FAIL rd_data_frame it%0d cyc=%0d data=%h exp=%0d,%h", it, rv_cyc, rv_data, RV_LAT, {2'b11, pay}); else pass_cnt++;
      bad = 0;
      for (int w = 0; w < d; w++) begin
        tick();
        if (o_miso !== 1'b0 || o_frame_err !== 1'b0) bad++;
      end
      a_if.tx_valid = 1'b1;
      a_if.tx_data  = data;
      tick();
      if (o_miso !== 1'b0) bad++;
      total_cnt++; if (bad != 0) $display("FAIL wait_tx_quiet it%0d bad_cycles=%0d exp=0", it, bad); else pass_cnt++;
      if (!level) a_if.tx_valid = 1'b0;
      for (int b = 0; b < 8; b++) begin
        logic exp_bit;
        exp_bit = data[7-b];
        if (level) a_if.tx_data = 8'($urandom);
        tick();
        total_cnt++; if (o_miso !== exp_bit) $display("FAIL miso_bit it%0d bit%0d got=%b exp=%b", it, b, o_miso, exp_bit); else pass_cnt++;
      end
      a_if.tx_valid = 1'b0;
      total_cnt++; if (o_rd_pending !== 1'b0 || o_busy !== 1'b1) $display("FAIL tx_end it%0d pend=%b busy=%b exp=0,1", it, o_rd_pending, o_busy); else pass_cnt++;
      tick();
      total_cnt++; if (o_miso !== 1'b0) $display("FAIL miso_after_tx it%0d got=%b exp=0", it, o_miso); else pass_cnt++;
      release_ss(1'b0);
      total_cnt++; if (o_busy !== 1'b0) $display("FAIL rd_release it%0d busy=%b exp=0", it, o_busy); else pass_cnt++;
    end
    pend_a = 1'b0;
  endtask

  task automatic test_abort();
    int k, n_rv;
    logic [1:0] cmd;
    logic [9:0] seq;
    int rv_cyc, n_ferr;
    logic [9:0] rv_data;
    cur = 1'b0;
    for (int it = 0; it < 6; it++) begin
      k   = (it == 0) ? 5 : $urandom_range(0, F_W - 1);
      cmd = (it == 0) ? 2'b00 : 2'($urandom);
      seq = frame_seq(cmd, 8'($urandom), 1'b1);
      n_rv = 0;
      set_in(1'b0, 1'b0, 1'b0);
      tick();
      for (int e = 0; e < k; e++) begin
        set_in(1'b0, 1'b0, seq[e]);
        tick();
        if (o_rx_valid === 1'b1 || o_frame_err === 1'b1) n_rv++;
      end
      set_in(1'b0, 1'b1, 1'b0);
      tick();
      total_cnt++; if (o_frame_err !== 1'b1 || o_busy !== 1'b0 || o_rx_valid !== 1'b0 || n_rv != 0) $display("FAIL abort_rx it%0d k=%0d ferr=%b busy=%b rv=%b early=%0d exp=1,0,0,0", it, k, o_frame_err, o_busy, o_rx_valid, n_rv); else pass_cnt++;
      total_cnt++; if (o_rx_data !== last_rx_a || o_rd_pending !== pend_a || o_miso !== 1'b0) $display("FAIL abort_keep it%0d data=%h pend=%b miso=%b exp=%h,%b,0", it, o_rx_data, o_rd_pending, o_miso, last_rx_a, pend_a); else pass_cnt++;
      tick();
      total_cnt++; if (o_frame_err !== 1'b0) $display("FAIL abort_pulse_len it%0d got=%b exp=0", it, o_frame_err); else pass_cnt++;
    end
    send_frame(1'b0, 2'b10, 8'h33, 1'b1, 1'b0, rv_cyc, rv_data, n_rv, n_ferr);
    release_ss(1'b0);
    pend_a = 1'b1;
    send_frame(1'b0, 2'b11, 8'h00, 1'b1, 1'b0, rv_cyc, rv_data, n_rv, n_ferr);
    last_rx_a = {2'b11, 8'h00};
    a_if.tx_valid = 1'b1;
    a_if.tx_data  = 8'hFF;
    tick();
    a_if.tx_valid = 1'b0;
    tick(); tick(); tick();
    total_cnt++; if (o_miso !== 1'b1) $display("FAIL abort_tx_pre got=%b exp=1", o_miso); else pass_cnt++;
    set_in(1'b0, 1'b1, 1'b0);
    tick();
    total_cnt++; if (o_frame_err !== 1'b1 || o_miso !== 1'b0 || o_busy !== 1'b0 || o_rd_pending !== pend_a) $display("FAIL abort_tx ferr=%b miso=%b busy=%b pend=%b exp=1,0,0,%b", o_frame_err, o_miso, o_busy, o_rd_pending, pend_a); else pass_cnt++;
    tick();
  endtask

  task automatic test_timeout();
    int rv_cyc, n_rv, n_ferr, first, miso_bad;
    logic [9:0] rv_data;
    send_frame(1'b0, 2'b10, 8'($urandom), 1'b1, 1'b0, rv_cyc, rv_data, n_rv, n_ferr);
    release_ss(1'b0);
    a_if.tx_valid = 1'b1;
    a_if.tx_data  = 8'hFF;
    send_frame(1'b0, 2'b11, 8'h00, 1'b1, 1'b0, rv_cyc, rv_data, n_rv, n_ferr);
    last_rx_a = {2'b11, 8'h00};
    a_if.tx_valid = 1'b0;
    total_cnt++; if (rv_cyc !== RV_LAT || o_rd_pending !== 1'b1) $display("FAIL tmo_frame cyc=%0d pend=%b exp=%0d,1", rv_cyc, o_rd_pending, RV_LAT); else pass_cnt++;
    first = -1; miso_bad = 0;
    for (int n = 1; n <= 30 && first < 0; n++) begin
      tick();
      if (o_miso !== 1'b0) miso_bad++;
      if (o_frame_err === 1'b1) first = n;
    end
    total_cnt++; if (first !== TMO_LAT) $display("FAIL tmo_latency got=%0d exp=%0d", first, TMO_LAT); else pass_cnt++;
    total_cnt++; if (miso_bad != 0 || o_rd_pending !== 1'b0 || o_busy !== 1'b1) $display("FAIL tmo_state miso_bad=%0d pend=%b busy=%b exp=0,0,1", miso_bad, o_rd_pending, o_busy); else pass_cnt++;
    pend_a = 1'b0;
    release_ss(1'b0);
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL tmo_release busy=%b exp=0", o_busy); else pass_cnt++;
  endtask

  task automatic test_rst_mid_tx();
    int rv_cyc, n_rv, n_ferr;
    logic [9:0] rv_data;
    logic [7:0] pay;
    send_frame(1'b0, 2'b10, 8'h12, 1'b1, 1'b0, rv_cyc, rv_data, n_rv, n_ferr);
    release_ss(1'b0);
    send_frame(1'b0, 2'b11, 8'h00, 1'b1, 1'b0, rv_cyc, rv_data, n_rv, n_ferr);
    a_if.tx_valid = 1'b1;
    a_if.tx_data  = 8'hFF;
    tick();
    a_if.tx_valid = 1'b0;
    tick(); tick(); tick();
    total_cnt++; if (o_miso !== 1'b1 || o_rd_pending !== 1'b1) $display("FAIL rst_pre miso=%b pend=%b exp=1,1", o_miso, o_rd_pending); else pass_cnt++;
    rst = 1'b1;
    set_in(1'b0, 1'b1, 1'b0);
    tick();
    total_cnt++; if (o_miso !== 1'b0 || o_rx_valid !== 1'b0 || o_frame_err !== 1'b0) $display("FAIL rst_pulses miso=%b rv=%b ferr=%b exp=0,0,0", o_miso, o_rx_valid, o_frame_err); else pass_cnt++;
    total_cnt++; if (o_rx_data !== 10'h0 || o_busy !== 1'b0 || o_rd_pending !== 1'b0) $display("FAIL rst_state data=%h busy=%b pend=%b exp=000,0,0", o_rx_data, o_busy, o_rd_pending); else pass_cnt++;
    rst = 1'b0;
    tick();
    pay = 8'($urandom);
    send_frame(1'b0, 2'b01, pay, 1'b1, 1'b1, rv_cyc, rv_data, n_rv, n_ferr);
    total_cnt++; if (rv_cyc !== RV_LAT || rv_data !== {2'b01, pay} || n_ferr !== 0) $display("FAIL post_rst_frame cyc=%0d data=%h ferr=%0d exp=%0d,%h,0", rv_cyc, rv_data, n_ferr, RV_LAT, {2'b01, pay}); else pass_cnt++;
    tick();
  endtask

  initial begin
    a_if.ss_n = 1'b1; a_if.mosi = 1'b0; a_if.tx_valid = 1'b0; a_if.tx_data = '0;
    b_if.ss_n = 1'b1; b_if.mosi = 1'b0; b_if.tx_valid = 1'b0; b_if.tx_data = '0;
    test_reset();
    test_rx_frames(1'b0);
    test_rx_frames(1'b1);
    test_read();
    test_abort();
    test_timeout();
    test_rst_mid_tx();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
